// File: rtl/saturn_bus_responder.sv
// saturn_bus_responder: nibble-serial bus responder for a Saturn-style bus controller.
// Holds the PC and DP nibble pointers, accumulates 5-nibble address loads, serves
// prefetched read nibbles and, optionally, streams data-pointer writes to memory.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_bus_clk_en          bus strobe; a transfer is its rising edge sampled on i_clk
//   i_bus_is_data         1 = data nibble, 0 = command nibble
//   i_bus_nibble_in       nibble from the bus controller
//   o_bus_nibble_out      registered read nibble, holds mem[pointer] in read modes
//   o_mem_addr            nibble address to backing memory
//   o_mem_re              one-clock read request, i_mem_data sampled on the next clock
//   i_mem_data            memory read data
//   o_mem_we, o_mem_wdata one-clock write strobe and data
//   o_busy                address load in progress
//   o_cmd_error           sticky unknown-command flag
//
// Build option: define RESPONDER_WRITE_EN to enable the DP_WRITE command (0x6).
// Without it 0x6 is an unknown command and the write outputs are tied low.

module saturn_bus_responder (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_bus_clk_en,
  input  logic        i_bus_is_data,
  input  logic [3:0]  i_bus_nibble_in,
  output logic [3:0]  o_bus_nibble_out,
  output logic [19:0] o_mem_addr,
  output logic        o_mem_re,
  input  logic [3:0]  i_mem_data,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_wdata,
  output logic        o_busy,
  output logic        o_cmd_error
);

  typedef enum logic [1:0] {StMode, StLoad, StFetch} state_e;
  typedef enum logic [1:0] {ModePcRead, ModeDpRead, ModeDpWrite} mode_e;

  state_e      state;
  mode_e       mode;
  logic [19:0] pc;
  logic [19:0] dp;
  logic [19:0] shadow;
  logic [2:0]  nib_cnt;
  logic        load_dp;
  logic        bus_prev;
  logic        pf_due;       // a prefetch must be issued before serving more transfers
  logic        pend_valid;
  logic        pend_is_data;
  logic [3:0]  pend_nib;

  logic        xfer;
  logic        use_valid;
  logic        use_is_data;
  logic [3:0]  use_nib;

  assign xfer = i_bus_clk_en & ~bus_prev;

  // A held transfer is always older than a live one, so it is served first.
  assign use_valid   = pend_valid | xfer;
  assign use_is_data = pend_valid ? pend_is_data : i_bus_is_data;
  assign use_nib     = pend_valid ? pend_nib : i_bus_nibble_in;

`ifdef RESPONDER_WRITE_EN
  logic       we_r;
  logic [3:0] wdata_r;
  assign o_mem_we    = we_r;
  assign o_mem_wdata = wdata_r;
`else
  assign o_mem_we    = 1'b0;
  assign o_mem_wdata = 4'h0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= StMode;
      mode             <= ModePcRead;
      pc               <= '0;
      dp               <= '0;
      shadow           <= '0;
      nib_cnt          <= '0;
      load_dp          <= 1'b0;
      bus_prev         <= 1'b0;
      pf_due           <= 1'b1;
      pend_valid       <= 1'b0;
      pend_is_data     <= 1'b0;
      pend_nib         <= '0;
      o_bus_nibble_out <= '0;
      o_mem_addr       <= '0;
      o_mem_re         <= 1'b0;
      o_busy           <= 1'b0;
      o_cmd_error      <= 1'b0;
`ifdef RESPONDER_WRITE_EN
      we_r             <= 1'b0;
      wdata_r          <= '0;
`endif
    end else begin
      bus_prev <= i_bus_clk_en;
      o_mem_re <= 1'b0;
`ifdef RESPONDER_WRITE_EN
      we_r     <= 1'b0;
`endif
      if (state == StFetch) begin
        o_bus_nibble_out <= i_mem_data;
        state            <= StMode;
        if (xfer && !pend_valid) begin
          pend_valid   <= 1'b1;
          pend_is_data <= i_bus_is_data;
          pend_nib     <= i_bus_nibble_in;
        end
      end else if (state == StMode && pf_due) begin
        o_mem_addr <= (mode == ModePcRead) ? pc : dp;
        o_mem_re   <= 1'b1;
        pf_due     <= 1'b0;
        state      <= StFetch;
        if (xfer && !pend_valid) begin
          pend_valid   <= 1'b1;
          pend_is_data <= i_bus_is_data;
          pend_nib     <= i_bus_nibble_in;
        end
      end else if (use_valid) begin
        // Serving the held transfer: a coincident live one takes its slot.
        if (pend_valid) begin
          pend_valid   <= xfer;
          pend_is_data <= i_bus_is_data;
          pend_nib     <= i_bus_nibble_in;
        end
        if (!use_is_data) begin
          // Any command aborts a load in progress before being decoded.
          state  <= StMode;
          o_busy <= 1'b0;
          case (use_nib)
            4'h2, 4'h4: begin
              state   <= StLoad;
              o_busy  <= 1'b1;
              nib_cnt <= '0;
              load_dp <= use_nib[2];
            end
            4'h3: begin
              mode   <= ModePcRead;
              pf_due <= 1'b1;
            end
            4'h5: begin
              mode   <= ModeDpRead;
              pf_due <= 1'b1;
            end
`ifdef RESPONDER_WRITE_EN
            4'h6: mode <= ModeDpWrite;
`endif
            default: o_cmd_error <= 1'b1;
          endcase
        end else if (state == StLoad) begin
          // Low nibble arrives first; after five shifts it sits in [3:0].
          shadow <= {use_nib, shadow[19:4]};
          if (nib_cnt == 3'd4) begin
            if (load_dp) dp <= {use_nib, shadow[19:4]};
            else         pc <= {use_nib, shadow[19:4]};
            state  <= StMode;
            o_busy <= 1'b0;
            pf_due <= 1'b1;
          end else begin
            nib_cnt <= nib_cnt + 3'd1;
          end
        end else begin
          case (mode)
            ModePcRead: begin
              pc     <= pc + 20'd1;
              pf_due <= 1'b1;
            end
            ModeDpRead: begin
              dp     <= dp + 20'd1;
              pf_due <= 1'b1;
            end
            default: begin
`ifdef RESPONDER_WRITE_EN
              we_r       <= 1'b1;
              wdata_r    <= use_nib;
              o_mem_addr <= dp;
              dp         <= dp + 20'd1;
`endif
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_saturn_bus_responder.sv
// Self-checking bench for saturn_bus_responder: directed vector table, hand-written
// multi-cycle sequences and randomized transfers against a transfer-level model.
module tb_saturn_bus_responder;

  logic        clk;
  logic        rst;
  logic        bus_en;
  logic        bus_is_data;
  logic [3:0]  bus_nib;
  logic [3:0]  nib_out;
  logic [19:0] mem_addr;
  logic        mem_re;
  logic [3:0]  mem_data;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic        busy;
  logic        cmd_err;

  saturn_bus_responder dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_bus_clk_en     (bus_en),
    .i_bus_is_data    (bus_is_data),
    .i_bus_nibble_in  (bus_nib),
    .o_bus_nibble_out (nib_out),
    .o_mem_addr       (mem_addr),
    .o_mem_re         (mem_re),
    .i_mem_data       (mem_data),
    .o_mem_we         (mem_we),
    .o_mem_wdata      (mem_wdata),
    .o_busy           (busy),
    .o_cmd_error      (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RESPONDER_WRITE_EN
  localparam bit WriteEn = 1'b1;
`else
  localparam bit WriteEn = 1'b0;
`endif

  // Read-only memory contents as a pure function of address; mem[0] = 0xA.
  function automatic logic [3:0] mem_val(input logic [19:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16] ^ 4'hA;
  endfunction

  assign mem_data = mem_val(mem_addr);

  logic [23:0] wlog[$];
  always @(posedge clk) if (mem_we) wlog.push_back({mem_addr, mem_wdata});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transfer-level reference model.
  logic [19:0] m_pc, m_dp, m_sh;
  int          m_mode;   // 0 PC_READ, 1 DP_READ, 2 DP_WRITE
  bit          m_load, m_tgt_dp, m_err;
  int          m_cnt;
  logic [23:0] m_wr[$];

  task automatic model_reset();
    m_pc = '0; m_dp = '0; m_sh = '0; m_mode = 0;
    m_load = 0; m_tgt_dp = 0; m_err = 0; m_cnt = 0;
    m_wr.delete();
  endtask

  task automatic model_apply(input bit is_data, input logic [3:0] nib);
    if (!is_data) begin
      m_load = 0;
      case (nib)
        4'h2, 4'h4: begin m_load = 1; m_tgt_dp = (nib == 4'h4); m_cnt = 0; m_sh = '0; end
        4'h3: m_mode = 0;
        4'h5: m_mode = 1;
        4'h6: if (WriteEn) m_mode = 2; else m_err = 1;
        default: m_err = 1;
      endcase
    end else if (m_load) begin
      m_sh = m_sh | (20'(nib) << (4 * m_cnt));
      m_cnt++;
      if (m_cnt == 5) begin
        if (m_tgt_dp) m_dp = m_sh; else m_pc = m_sh;
        m_load = 0;
      end
    end else if (m_mode == 0) begin
      m_pc = (m_pc + 20'd1) & 20'hFFFFF;
    end else if (m_mode == 1) begin
      m_dp = (m_dp + 20'd1) & 20'hFFFFF;
    end else begin
      m_wr.push_back({m_dp, nib});
      m_dp = (m_dp + 20'd1) & 20'hFFFFF;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(m_load));
    chk({tag, "_err"}, 32'(cmd_err), 32'(m_err));
    if (m_mode != 2)
      chk({tag, "_nibble"}, 32'(nib_out), 32'(mem_val(m_mode == 0 ? m_pc : m_dp)));
    chk({tag, "_wr_count"}, wlog.size(), m_wr.size());
    for (int i = 0; i < m_wr.size() && i < wlog.size(); i++)
      chk({tag, "_wr_entry"}, 32'(wlog[i]), 32'(m_wr[i]));
    wlog.delete();
    m_wr.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("reset_outputs", {nib_out, mem_addr, mem_re, mem_we, mem_wdata, busy, cmd_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("init_prefetch", {11'h0, mem_re, mem_addr}, {11'h0, 1'b1, 20'h0});
    @(negedge clk);
    chk("init_nibble", {31'h0, mem_re, nib_out}, {31'h0, 1'b0, mem_val(20'h0)});
    wlog.delete();
  endtask

  task automatic xfer(input bit is_data, input logic [3:0] nib);
    @(negedge clk);
    bus_is_data = is_data;
    bus_nib     = nib;
    bus_en      = 1'b1;
    @(negedge clk);
    bus_en = 1'b0;
    repeat (4) @(negedge clk);
    model_apply(is_data, nib);
  endtask

  typedef struct {
    bit          is_data;
    logic [3:0]  nib;
    bit          exp_busy;
    logic [19:0] exp_ptr;   // pointer whose memory nibble must be on the output
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_en = 1'b0; bus_is_data = 1'b0; bus_nib = 4'h0;
    model_reset();

    vecs.push_back('{0, 4'h2, 1, 20'h00000});
    vecs.push_back('{1, 4'h5, 1, 20'h00000});
    vecs.push_back('{1, 4'h4, 1, 20'h00000});
    vecs.push_back('{1, 4'h3, 1, 20'h00000});
    vecs.push_back('{1, 4'h2, 1, 20'h00000});
    vecs.push_back('{1, 4'h1, 0, 20'h12345});
    vecs.push_back('{0, 4'h3, 0, 20'h12345});
    vecs.push_back('{1, 4'h0, 0, 20'h12346});
    vecs.push_back('{1, 4'h0, 0, 20'h12347});
    vecs.push_back('{1, 4'h0, 0, 20'h12348});
    vecs.push_back('{0, 4'h4, 1, 20'h12348});
    for (int i = 0; i < 4; i++) vecs.push_back('{1, 4'hF, 1, 20'h12348});
    vecs.push_back('{1, 4'hF, 0, 20'h12348});
    vecs.push_back('{0, 4'h5, 0, 20'hFFFFF});
    vecs.push_back('{1, 4'h0, 0, 20'h00000});
    vecs.push_back('{1, 4'h0, 0, 20'h00001});
    vecs.push_back('{0, 4'h4, 1, 20'h00001});
    vecs.push_back('{1, 4'h1, 1, 20'h00001});
    vecs.push_back('{1, 4'h2, 1, 20'h00001});
    vecs.push_back('{0, 4'h3, 0, 20'h12348});
    vecs.push_back('{0, 4'h5, 0, 20'h00001});

    do_reset();

    foreach (vecs[i]) begin
      xfer(vecs[i].is_data, vecs[i].nib);
      chk($sformatf("vec%0d_nibble", i), 32'(nib_out), 32'(mem_val(vecs[i].exp_ptr)));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_err", i), 32'(cmd_err), 32'h0);
    end

    // DP write stream at 0x00100.
    begin
      logic [23:0] exp_w[$];
      do_reset();
      xfer(0, 4'h4);
      xfer(1, 4'h0); xfer(1, 4'h0); xfer(1, 4'h1); xfer(1, 4'h0); xfer(1, 4'h0);
      xfer(0, 4'h6);
      xfer(1, 4'h7);
      xfer(1, 4'h8);
`ifdef RESPONDER_WRITE_EN
      exp_w.push_back(24'h001007);
      exp_w.push_back(24'h001018);
`endif
      chk("dpw_count", wlog.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
        chk("dpw_entry", 32'(wlog[i]), 32'(exp_w[i]));
      chk("dpw_err", 32'(cmd_err), 32'(!WriteEn));
      model_check("dpw");
    end

    // Unknown command is sticky.
    xfer(0, 4'hF);
    model_check("unk");
    xfer(0, 4'h3); xfer(1, 4'h0); xfer(0, 4'h5);
    model_check("unk_sticky");

    // Strobe held high for 10 clocks counts once.
    do_reset();
    @(negedge clk);
    bus_is_data = 1'b1; bus_nib = 4'h0; bus_en = 1'b1;
    repeat (10) @(negedge clk);
    bus_en = 1'b0;
    repeat (4) @(negedge clk);
    model_apply(1, 4'h0);
    model_check("held");

    // Three back-to-back reads exercise the pending slot during prefetch.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_is_data = 1'b1; bus_en = 1'b1;
      @(negedge clk);
      bus_en = 1'b0;
      model_apply(1, 4'h0);
    end
    repeat (8) @(negedge clk);
    model_check("burst");

    // Reset mid-LOAD discards the partial address.
    xfer(0, 4'h2); xfer(1, 4'h1); xfer(1, 4'h2);
    do_reset();
    xfer(0, 4'h3);
    model_check("midload");
    xfer(1, 4'h0); xfer(1, 4'h0); xfer(1, 4'h0);
    model_check("midload_reads");

    // Reset while a prefetch is in flight.
    @(negedge clk);
    bus_is_data = 1'b1; bus_en = 1'b1;
    @(negedge clk);
    bus_en = 1'b0;
    do_reset();
    model_check("midfetch");

    // Randomized transfers against the model.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0: xfer(0, 4'h2);
        1: xfer(0, 4'h4);
        2: xfer(0, 4'h3);
        3: xfer(0, 4'h5);
        4: xfer(0, 4'h6);
        5: xfer(0, 4'($urandom_range(0, 15)));
        default: xfer(1, 4'($urandom_range(0, 15)));
      endcase
      model_check($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
